rs232_tx_scheduler: RTL and testbench
=====================================

# rs232_tx_scheduler

Round-robin transmit scheduler that shares the single RS232 UART Avalon slave among up to NUM_REQ byte-stream requesters. It acts as the sole Avalon master on the UART register port. It polls the control register for transmit FIFO space, keeps a local write credit, and writes bytes to the data register. It optionally holds the grant for a whole packet, so bytes from different requesters never interleave on UART_TXD.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- LOCK_EN, 1: 1 = grant held until a byte with req_last is sent; 0 = grant released after every byte.
- HOLD_TIMEOUT, 16: cycles a locked grant waits for the owner's next byte before being released (8-bit counter).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a byte on req_data[8i+7:8i].
- req_data  in  8*NUM_REQ  packed request bytes.
- req_last  in  NUM_REQ  byte is the last byte of its packet.
- req_ready  out  NUM_REQ  one-hot pulse; the byte of requester i is consumed this cycle.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy  out  1  FSM not in IDLE.
- address  out  1  UART register select: 0 = data, 1 = control.
- chipselect, read, write  out  1 each  Avalon master strobes.
- byteenable  out  4  Avalon byte enables.
- writedata  out  32  Avalon write data.
- readdata  in  32  UART read data; valid the cycle after a read strobe. No waitrequest.

## Operation
- States: IDLE, ARB, POLL, CHECK, WRITE, SETTLE, HOLD.
- IDLE -> ARB when any req_valid is high.
- ARB:
  - Select the first valid requester at or after rr_ptr (modulo NUM_REQ) and set grant one-hot.
  - If credit > 0, go to WRITE; otherwise go to POLL.
- POLL (1 cycle): chipselect=1, read=1, address=1, byteenable=4'hF. Then -> CHECK.
- CHECK: credit <= readdata[23:16] (write_space).
  - If write_space == 0, go to SETTLE and re-poll.
  - Otherwise go to WRITE.
- WRITE (1 cycle):
  - Bus: chipselect=1, write=1, address=0, byteenable=4'b0001, writedata={24'h0, byte of granted requester}.
  - Pulse req_ready of the granted requester; credit decrements by 1. Then -> SETTLE.
- SETTLE (exactly 2 cycles, counted by a 1-bit counter): lets the slave's registered write enable and FIFO count catch up. It then branches:
  - Release (LOCK_EN=0, or the byte just sent had req_last=1): rr_ptr <= owner+1 mod NUM_REQ; grant <= 0; -> IDLE.
  - Otherwise, if the owner's req_valid is high: -> POLL if credit == 0, else -> WRITE.
  - Otherwise -> HOLD.
  - A SETTLE entered from CHECK with space 0 always returns to POLL, grant unchanged.
- HOLD: counts cycles from 0.
  - Owner's req_valid rises: -> POLL or WRITE, same credit rule.
  - Count reaches HOLD_TIMEOUT-1: release exactly as above.
- Credit: 8-bit, saturates at 0, never incremented except by CHECK load. It persists across grants, so a new owner may write without polling.
- In cycles without a strobe, all Avalon outputs are 0 (writedata holds its last value).
- A requester's byte is consumed only on its req_ready pulse. Requesters must hold req_valid and req_data stable until then.
- A requester dropping req_valid while granted but not in WRITE is legal; it leads to HOLD.

## Timing
- Reset values: state IDLE, grant 0, req_ready 0, busy 0, chipselect/read/write 0, address 0, byteenable 0, writedata 0, credit 0, rr_ptr 0, counters 0. Reset mid-transfer aborts immediately; any pending byte is not consumed.
- First byte from idle with credit 0:
  - req_valid seen in cycle T (IDLE).
  - ARB at T+1, POLL at T+2, CHECK at T+3, WRITE at T+4.
  - req_ready at T+4.
- With credit > 0, the write cadence is one byte per 3 cycles (WRITE plus 2 SETTLE cycles).
- Arbitration is registered; req_valid changes in the ARB cycle do not affect the choice until the next ARB.
- Simultaneous requests: the lowest index at or after rr_ptr wins. No requester waits more than NUM_REQ-1 packets.

## Test plan
- Single requester 0 sends 3 bytes 0x41,0x42,0x43 with last on the 3rd; UART space 128:
  - Exactly one read (address=1), then three writes (address=0, writedata 0x41/0x42/0x43).
  - req_ready on cycles T+4, T+7, T+10; grant returns to 0.
- Requesters 0 and 2 each present 2-byte packets simultaneously, LOCK_EN=1:
  - Write order is 0a,0b,2a,2b. rr_ptr ends at 3.
  - The next simultaneous request from 0 and 3 grants 3 first.
- Full FIFO: write_space=0 on the first two polls, then 5:
  - Read strobes repeat every 4 cycles (POLL, CHECK, 2×SETTLE).
  - No write before space > 0; credit loads 5 and then a 5-byte packet writes with no further polls.
- Owner 1 stalls mid-packet, LOCK_EN=1, HOLD_TIMEOUT=16, with requester 2 valid:
  - Grant stays on 1 for 16 HOLD cycles, then moves to 2.
  - When owner 1 resumes within 10 cycles instead, it keeps the grant.
- reset asserted during a WRITE cycle of a 4-byte packet: all outputs return to 0 asynchronously, credit 0. After release, the packet restarts with a POLL.
- LOCK_EN=0, requesters 0 and 1 each stream 2 bytes: writes interleave 0,1,0,1.

Source files
------------

// File: rtl/rs232_tx_scheduler.sv
// Round-robin transmit scheduler: shares one RS232 UART Avalon slave among NUM_REQ
// byte-stream requesters, polling TX FIFO space and keeping a local write credit.
module rs232_tx_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter bit          LOCK_EN      = 1'b1,
  parameter int unsigned HOLD_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 address,
  output logic                 chipselect,
  output logic                 read,
  output logic                 write,
  output logic [3:0]           byteenable,
  output logic [31:0]          writedata,
  input  logic [31:0]          readdata
);

  localparam int unsigned OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_POLL, S_CHECK, S_WRITE, S_SETTLE, S_HOLD
  } state_e;

  state_e        state_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] rr_ptr_q;
  logic [7:0]    credit_q;
  logic [7:0]    hold_cnt_q;
  logic          settle_cnt_q;
  logic          repoll_q;
  logic          last_q;

  logic [OW-1:0] pick_idx_d;
  logic          pick_vld_d;
  logic [OW-1:0] rr_next_d;
  logic          own_valid;
  logic          own_last;
  logic [7:0]    own_data;
  logic [7:0]    space;
  logic          unused_rd;

  // First valid requester at or after rr_ptr; descending scan lets the nearest win.
  always_comb begin
    int idx;
    pick_idx_d = '0;
    pick_vld_d = 1'b0;
    idx        = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (req_valid[OW'(idx)]) begin
        pick_idx_d = OW'(idx);
        pick_vld_d = 1'b1;
      end
    end
  end

  assign rr_next_d = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign own_data  = req_data[{owner_q, 3'b000} +: 8];
  assign space     = readdata[23:16];
  assign unused_rd = ^{readdata[31:24], readdata[15:0]};
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      credit_q     <= 8'd0;
      hold_cnt_q   <= 8'd0;
      settle_cnt_q <= 1'b0;
      repoll_q     <= 1'b0;
      last_q       <= 1'b0;
      grant        <= '0;
      req_ready    <= '0;
      address      <= 1'b0;
      chipselect   <= 1'b0;
      read         <= 1'b0;
      write        <= 1'b0;
      byteenable   <= 4'h0;
      writedata    <= 32'h0;
    end else begin
      chipselect <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= 1'b0;
      byteenable <= 4'h0;
      req_ready  <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            grant   <= NUM_REQ'(1) << pick_idx_d;
            owner_q <= pick_idx_d;
            state_q <= S_ARB;
          end
        end
        S_ARB: begin
          if (credit_q == 8'd0) begin
            {chipselect, read, address} <= 3'b111;
            byteenable <= 4'hF;
            state_q    <= S_POLL;
          end else if (own_valid) begin
            {chipselect, write} <= 2'b11;
            byteenable <= 4'b0001;
            writedata  <= {24'h0, own_data};
            req_ready  <= grant;
            last_q     <= own_last;
            state_q    <= S_WRITE;
          end else begin
            hold_cnt_q <= 8'd0;
            state_q    <= S_HOLD;
          end
        end
        S_POLL: state_q <= S_CHECK;
        S_CHECK: begin
          credit_q <= space;
          if (space == 8'd0) begin
            repoll_q     <= 1'b1;
            settle_cnt_q <= 1'b0;
            state_q      <= S_SETTLE;
          end else if (own_valid) begin
            {chipselect, write} <= 2'b11;
            byteenable <= 4'b0001;
            writedata  <= {24'h0, own_data};
            req_ready  <= grant;
            last_q     <= own_last;
            state_q    <= S_WRITE;
          end else begin
            hold_cnt_q <= 8'd0;
            state_q    <= S_HOLD;
          end
        end
        S_WRITE: begin
          credit_q     <= (credit_q != 8'd0) ? credit_q - 8'd1 : 8'd0;
          repoll_q     <= 1'b0;
          settle_cnt_q <= 1'b0;
          state_q      <= S_SETTLE;
        end
        S_SETTLE: begin
          settle_cnt_q <= ~settle_cnt_q;
          if (settle_cnt_q) begin
            if (repoll_q) begin
              repoll_q <= 1'b0;
              {chipselect, read, address} <= 3'b111;
              byteenable <= 4'hF;
              state_q    <= S_POLL;
            end else if (!LOCK_EN || last_q) begin
              rr_ptr_q <= rr_next_d;
              grant    <= '0;
              state_q  <= S_IDLE;
            end else if (own_valid && credit_q == 8'd0) begin
              {chipselect, read, address} <= 3'b111;
              byteenable <= 4'hF;
              state_q    <= S_POLL;
            end else if (own_valid) begin
              {chipselect, write} <= 2'b11;
              byteenable <= 4'b0001;
              writedata  <= {24'h0, own_data};
              req_ready  <= grant;
              last_q     <= own_last;
              state_q    <= S_WRITE;
            end else begin
              hold_cnt_q <= 8'd0;
              state_q    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Owner keeps the grant while mid-packet, up to HOLD_TIMEOUT idle cycles.
          if (own_valid && credit_q == 8'd0) begin
            {chipselect, read, address} <= 3'b111;
            byteenable <= 4'hF;
            state_q    <= S_POLL;
          end else if (own_valid) begin
            {chipselect, write} <= 2'b11;
            byteenable <= 4'b0001;
            writedata  <= {24'h0, own_data};
            req_ready  <= grant;
            last_q     <= own_last;
            state_q    <= S_WRITE;
          end else if (hold_cnt_q == HOLD_LAST) begin
            rr_ptr_q <= rr_next_d;
            grant    <= '0;
            state_q  <= S_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx_scheduler.sv
// Directed bench for rs232_tx_scheduler: a locked instance and an unlocked
// instance, each with queue-driven requesters and a UART control/data slave model.
module tb_rs232_tx_scheduler;

  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid  [2];
  logic [8*NR-1:0] req_data   [2];
  logic [NR-1:0]   req_last   [2];
  logic [NR-1:0]   req_ready  [2];
  logic [NR-1:0]   grant      [2];
  logic            busy       [2];
  logic            address    [2];
  logic            chipselect [2];
  logic            read       [2];
  logic            write      [2];
  logic [3:0]      byteenable [2];
  logic [31:0]     writedata  [2];
  logic [31:0]     readdata   [2];

  rs232_tx_scheduler #(.NUM_REQ(NR), .LOCK_EN(1'b1), .HOLD_TIMEOUT(16)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_data(req_data[0]),
    .req_last(req_last[0]), .req_ready(req_ready[0]), .grant(grant[0]), .busy(busy[0]),
    .address(address[0]), .chipselect(chipselect[0]), .read(read[0]), .write(write[0]),
    .byteenable(byteenable[0]), .writedata(writedata[0]), .readdata(readdata[0]));

  rs232_tx_scheduler #(.NUM_REQ(NR), .LOCK_EN(1'b0), .HOLD_TIMEOUT(16)) u_dut_nolock (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_data(req_data[1]),
    .req_last(req_last[1]), .req_ready(req_ready[1]), .grant(grant[1]), .busy(busy[1]),
    .address(address[1]), .chipselect(chipselect[1]), .read(read[1]), .write(write[1]),
    .byteenable(byteenable[1]), .writedata(writedata[1]), .readdata(readdata[1]));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [8:0]    rq      [2][NR][$];
  logic [7:0]    space_q [2][$];
  int            rd_cyc  [2][$];
  int            wr_cyc  [2][$];
  int            wr_own  [2][$];
  int            rdy_cyc [2][$];
  logic [7:0]    wr_byte [2][$];
  logic [NR-1:0] glog    [2][4096];
  logic [7:0]    exp_b [$];
  int            exp_o [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int oh2i(input logic [NR-1:0] g);
    oh2i = -1;
    for (int i = 0; i < NR; i++) if (g[i]) oh2i = i;
  endfunction

  function automatic bit q_empty(input int d);
    for (int i = 0; i < NR; i++) if (rq[d][i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // UART slave: control read returns write_space in [23:16] one cycle after the strobe.
  always @(posedge clk) begin
    logic [7:0] sp;
    for (int d = 0; d < 2; d++) begin
      if (chipselect[d] && read[d] && address[d]) begin
        sp = 8'd128;
        if (space_q[d].size() > 0) sp = space_q[d].pop_front();
        readdata[d] <= {8'h00, sp, 16'h0000};
      end else begin
        readdata[d] <= 32'h0;
      end
    end
  end

  // Bus monitor plus requester models; requesters pop a byte only on req_ready.
  always @(negedge clk) begin
    logic [8:0] h;
    for (int d = 0; d < 2; d++) begin
      if (cyc < 4096) glog[d][cyc] = grant[d];
      if (chipselect[d] && write[d] && !address[d]) begin
        wr_cyc[d].push_back(cyc);
        wr_byte[d].push_back(writedata[d][7:0]);
        wr_own[d].push_back(oh2i(grant[d]));
        check("wr_be", 32'(byteenable[d]), 32'h1);
      end
      if (chipselect[d] && read[d] && address[d]) begin
        rd_cyc[d].push_back(cyc);
        check("rd_be", 32'(byteenable[d]), 32'hF);
      end
      if (|req_ready[d]) rdy_cyc[d].push_back(cyc);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[d][i] && rq[d][i].size() > 0) void'(rq[d][i].pop_front());
        h = 9'h0;
        if (rq[d][i].size() > 0) h = rq[d][i][0];
        req_valid[d][i]      = (rq[d][i].size() > 0);
        req_data[d][8*i +: 8] = h[7:0];
        req_last[d][i]       = h[8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      rd_cyc[d].delete(); wr_cyc[d].delete(); wr_own[d].delete();
      rdy_cyc[d].delete(); wr_byte[d].delete(); space_q[d].delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    tick();
  endtask

  task automatic wait_done(input int d, input string tag);
    int n;
    n = 0;
    while (n < 300 && !(busy[d] == 1'b0 && q_empty(d))) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 300), 32'h1);
    tick();
  endtask

  task automatic wait_writes(input int d, input int cnt, input string tag);
    int n;
    n = 0;
    while (n < 200 && wr_byte[d].size() < cnt) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 200), 32'h1);
  endtask

  task automatic check_wr(input int d, input string tag);
    check({tag, "_cnt"}, 32'(wr_byte[d].size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < wr_byte[d].size(); i++) begin
      check({tag, "_byte"}, 32'(wr_byte[d][i]), 32'(exp_b[i]));
      check({tag, "_own"}, 32'(wr_own[d][i]), 32'(exp_o[i]));
    end
  endtask

  initial begin
    int t0, tw, bad, n;
    reset = 1'b1;
    tick(); tick(); tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_grant", 32'(grant[d]), 32'h0);
      check("rst_ready", 32'(req_ready[d]), 32'h0);
      check("rst_busy", 32'(busy[d]), 32'h0);
      check("rst_strobes", 32'({chipselect[d], read[d], write[d], address[d]}), 32'h0);
      check("rst_be", 32'(byteenable[d]), 32'h0);
      check("rst_wdata", writedata[d], 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    tick();

    // Single requester, 3-byte packet, space 128.
    t0 = cyc;
    rq[0][0].push_back({1'b0, 8'h41});
    rq[0][0].push_back({1'b0, 8'h42});
    rq[0][0].push_back({1'b1, 8'h43});
    wait_done(0, "t1_done");
    check("t1_reads", 32'(rd_cyc[0].size()), 32'd1);
    if (rd_cyc[0].size() > 0) check("t1_rd_cyc", 32'(rd_cyc[0][0]), 32'(t0 + 2));
    exp_b = '{8'h41, 8'h42, 8'h43};
    exp_o = '{0, 0, 0};
    check_wr(0, "t1");
    check("t1_rdy_cnt", 32'(rdy_cyc[0].size()), 32'd3);
    for (int i = 0; i < 3 && i < rdy_cyc[0].size(); i++)
      check("t1_rdy_cyc", 32'(rdy_cyc[0][i]), 32'(t0 + 4 + 3 * i));
    check("t1_grant_end", 32'(grant[0]), 32'h0);

    // Locked packets from 0 and 2 do not interleave; rr_ptr then favours 3 over 0.
    do_reset();
    rq[0][0].push_back({1'b0, 8'hA0});
    rq[0][0].push_back({1'b1, 8'hA1});
    rq[0][2].push_back({1'b0, 8'hC0});
    rq[0][2].push_back({1'b1, 8'hC1});
    wait_done(0, "t2_done");
    exp_b = '{8'hA0, 8'hA1, 8'hC0, 8'hC1};
    exp_o = '{0, 0, 2, 2};
    check_wr(0, "t2");
    clear_logs();
    rq[0][0].push_back({1'b1, 8'hE0});
    rq[0][3].push_back({1'b1, 8'hF3});
    wait_done(0, "t2b_done");
    exp_b = '{8'hF3, 8'hE0};
    exp_o = '{3, 0};
    check_wr(0, "t2b");

    // Full FIFO: two zero-space polls, then space 5 covers the 5-byte packet.
    do_reset();
    space_q[0].push_back(8'd0);
    space_q[0].push_back(8'd0);
    space_q[0].push_back(8'd5);
    t0 = cyc;
    for (int i = 0; i < 5; i++) rq[0][0].push_back({i == 4, 8'(8'h10 + i)});
    wait_done(0, "t3_done");
    check("t3_reads", 32'(rd_cyc[0].size()), 32'd3);
    for (int i = 0; i < 3 && i < rd_cyc[0].size(); i++)
      check("t3_rd_cyc", 32'(rd_cyc[0][i]), 32'(t0 + 2 + 4 * i));
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    exp_o = '{0, 0, 0, 0, 0};
    check_wr(0, "t3");
    for (int i = 0; i < 5 && i < wr_cyc[0].size(); i++)
      check("t3_wr_cyc", 32'(wr_cyc[0][i]), 32'(t0 + 12 + 3 * i));

    // Owner 1 stalls mid-packet with requester 2 waiting: timeout hands over.
    do_reset();
    rq[0][1].push_back({1'b0, 8'h51});
    rq[0][2].push_back({1'b1, 8'h61});
    wait_writes(0, 1, "t4_first");
    tw = (rdy_cyc[0].size() > 0) ? rdy_cyc[0][0] : 0;
    wait_done(0, "t4_done");
    bad = 0;
    for (int k = 0; k <= 18; k++) if (glog[0][tw + k] != 4'b0010) bad++;
    check("t4_hold_grant", 32'(bad), 32'd0);
    check("t4_release", 32'(glog[0][tw + 19]), 32'h0);
    check("t4_new_grant", 32'(glog[0][tw + 20]), 32'b0100);
    exp_b = '{8'h51, 8'h61};
    exp_o = '{1, 2};
    check_wr(0, "t4");
    if (wr_cyc[0].size() > 1) check("t4_wr2_cyc", 32'(wr_cyc[0][1]), 32'(tw + 21));

    // Owner 1 resumes within the hold window and keeps the grant.
    clear_logs();
    rq[0][1].push_back({1'b0, 8'h71});
    rq[0][2].push_back({1'b1, 8'h81});
    wait_writes(0, 1, "t4b_first");
    tw = (rdy_cyc[0].size() > 0) ? rdy_cyc[0][0] : 0;
    repeat (6) tick();
    rq[0][1].push_back({1'b1, 8'h72});
    wait_done(0, "t4b_done");
    exp_b = '{8'h71, 8'h72, 8'h81};
    exp_o = '{1, 1, 2};
    check_wr(0, "t4b");
    if (wr_cyc[0].size() > 1) check("t4b_resume_cyc", 32'(wr_cyc[0][1]), 32'(tw + 8));

    // Reset during the second WRITE of a 4-byte packet.
    clear_logs();
    for (int i = 0; i < 4; i++) rq[0][0].push_back({i == 3, 8'(8'h90 + i)});
    wait_writes(0, 1, "t5_first");
    n = 0;
    tick();
    while (n < 20 && !(chipselect[0] && write[0])) begin
      tick();
      n++;
    end
    check("t5_wr_found", 32'(n < 20), 32'h1);
    reset = 1'b1;
    #1;
    check("t5_rst_ready", 32'(req_ready[0]), 32'h0);
    check("t5_rst_strobes", 32'({chipselect[0], read[0], write[0], address[0]}), 32'h0);
    check("t5_rst_grant", 32'(grant[0]), 32'h0);
    check("t5_rst_busy", 32'(busy[0]), 32'h0);
    check("t5_rst_wdata", writedata[0], 32'h0);
    @(negedge clk);
    @(negedge clk);
    clear_logs();
    reset = 1'b0;
    check("t5_pending", 32'(rq[0][0].size()), 32'd3);
    tick();
    wait_done(0, "t5_done");
    check("t5_reads", 32'(rd_cyc[0].size()), 32'd1);
    if (rd_cyc[0].size() > 0 && wr_cyc[0].size() > 0)
      check("t5_poll_first", 32'(rd_cyc[0][0] < wr_cyc[0][0]), 32'h1);
    exp_b = '{8'h91, 8'h92, 8'h93};
    exp_o = '{0, 0, 0};
    check_wr(0, "t5");

    // Unlocked instance interleaves per byte.
    rq[1][0].push_back({1'b0, 8'hB0});
    rq[1][0].push_back({1'b1, 8'hB1});
    rq[1][1].push_back({1'b0, 8'hD0});
    rq[1][1].push_back({1'b1, 8'hD1});
    wait_done(1, "t6_done");
    exp_b = '{8'hB0, 8'hD0, 8'hB1, 8'hD1};
    exp_o = '{0, 1, 0, 1};
    check_wr(1, "t6");
    check("t6_reads", 32'(rd_cyc[1].size()), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
